dsp_issue_sched: RTL and testbench
==================================

Name: dsp_issue_sched

Overview:
- Issue scheduler that shares one DSP_top instance between two requesters (R0, R1).
- Arbitrates round-robin and enforces the mode-dependent issue interval: mode 0 every cycle, mode 1 every 2 cycles, mode 2 every 4 cycles.
- Drains the pipeline before any mode change and holds a MAC lock so accumulation chains are not interleaved.
- Tags each issued operation and returns its result with requester id, in order.

Parameters:
- N, 16, DSP operand width (aa, bb); results and cc are 2N.
- LAT, 3, cycles from dsp_start to a valid dsp_out for a mode-0 op.
- ID_W, 4, width of the requester transaction id.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- r0_valid / r1_valid  in  1  request valid
- r0_ready / r1_ready  out  1  request accepted this cycle when valid&ready
- r0_aa, r0_bb / r1_aa, r1_bb  in  N  operands
- r0_cc / r1_cc  in  2N  addend
- r0_mode / r1_mode  in  2  DSP mode; 3 is treated as 2
- r0_mac / r1_mac  in  1  accumulate request
- r0_id / r1_id  in  ID_W  transaction id
- dsp_start  out  1  one-cycle issue pulse to DSP
- dsp_mode  out  2  to DSP
- dsp_mac  out  1  to DSP
- dsp_aa, dsp_bb  out  N  to DSP
- dsp_cc  out  2N  to DSP
- dsp_out  in  2N  DSP result
- rsp_valid  out  1  result valid (no backpressure)
- rsp_src  out  1  0=R0, 1=R1
- rsp_id  out  ID_W  id of completed op
- rsp_data  out  2N  dsp_out sampled at completion
- busy  out  1  any op in flight or cooldown active

Behaviour:
- Reset values:
  - All outputs 0; rr pointer = R0; cur_mode = 0; lock cleared; tag pipeline empty; cooldown = 0.
  - rst mid-operation discards all in-flight tags; no rsp_valid follows.
- II(mode) = 1 / 2 / 4 for mode 0 / 1 / 2.
- States:
  - IDLE: no cooldown.
  - COOL: counter > 0. Set to II-1 on issue and decrements each cycle. No grant while nonzero.
  - DRAIN: winner's mode ≠ cur_mode and tags in flight. No grant until the tag pipeline is empty, then return to IDLE.
- Arbitration (IDLE only):
  - Eligible = valid and not blocked by the lock.
  - If both are eligible, grant the requester pointed to by rr; rr flips to the other requester after each grant.
  - Exactly one ready is asserted, in the same cycle as dsp_start. Ready is combinational from state and valids.
- Issue:
  - dsp_* outputs are driven from the granted request's fields in the grant cycle.
  - cur_mode is updated on issue.
  - dsp_aa/bb/cc/mode/mac hold their last values when not issuing.
- MAC lock:
  - An issue with mac=1 sets lock owner = that requester; the other requester becomes ineligible.
  - An issue by the owner with mac=0 clears the lock. The rr pointer is frozen while locked.
- Completion:
  - The op issued at cycle t completes at cycle t+LAT+II(mode)-1.
  - At completion: rsp_valid=1; rsp_src, rsp_id from the tag; rsp_data=dsp_out in that same cycle.
  - Completions are in issue order, with at most one per cycle.
- Tag storage: shift register of depth LAT+3, capacity guaranteed by II enforcement; no overflow possible.
- busy = cooldown ≠ 0 or any tag valid.
- Simultaneous events:
  - A completion and an issue in the same cycle are both handled.
  - A drain exit and a grant may occur in the cycle the last tag retires.

Optional Feature:
- Macro SCHED_PERF_CNT_EN.
- When defined, adds:
  - outputs perf_issue0, perf_issue1 (32 bits each): accepted requests per requester.
  - output perf_stall (32 bits): cycles where any valid is high and no ready is asserted.
  - All three counters are cleared by rst and wrap at 2^32.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Mode 0, R0 only, 8 back-to-back requests aa=3, bb=5, cc=0, ids 0..7 -> ready every cycle; rsp_data=15 with ids 0..7 on 8 consecutive cycles starting LAT cycles after the first start.
- Mode 2, both valid continuously -> dsp_start every 4th cycle, alternating R0/R1; each rsp arrives LAT+3 cycles after its start with the correct rsp_src.
- R0 mode 0 followed by R0 mode 1 with 2 mode-0 ops in flight -> no start until both rsp_valid have fired, then the mode-1 start; busy stays high throughout.
- R0 mac=1 ×3, then mac=0, with R1 valid throughout -> R1 is not granted until after R0's mac=0 issue; the next grant goes to R1.
- Reset asserted one cycle after a mode-2 issue -> all outputs are 0 next cycle, no rsp_valid for that op, and a new request is granted in the first post-reset cycle.
- Mode 3 request -> handled as mode 2 (4-cycle interval, latency LAT+3).

Source files
------------

// File: rtl/dsp_issue_sched.sv
// dsp_issue_sched: shares one DSP between two requesters with round-robin, issue-interval and MAC-lock control
// Ports: clk/rst (sync, active-high); r0_*/r1_* valid/ready request channels carrying
// aa, bb, cc, mode, mac, id; dsp_* issue outputs to the DSP and dsp_out result input;
// rsp_valid/src/id/data in-order completion stream; busy while cooldown or tags in flight.
// Optional macro SCHED_PERF_CNT_EN adds perf_issue0, perf_issue1 and perf_stall counters.
module dsp_issue_sched #(
  parameter int N = 16,
  parameter int LAT = 3,
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [N-1:0]    r0_aa,
  input  logic [N-1:0]    r0_bb,
  input  logic [2*N-1:0]  r0_cc,
  input  logic [1:0]      r0_mode,
  input  logic            r0_mac,
  input  logic [ID_W-1:0] r0_id,
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [N-1:0]    r1_aa,
  input  logic [N-1:0]    r1_bb,
  input  logic [2*N-1:0]  r1_cc,
  input  logic [1:0]      r1_mode,
  input  logic            r1_mac,
  input  logic [ID_W-1:0] r1_id,
  output logic            dsp_start,
  output logic [1:0]      dsp_mode,
  output logic            dsp_mac,
  output logic [N-1:0]    dsp_aa,
  output logic [N-1:0]    dsp_bb,
  output logic [2*N-1:0]  dsp_cc,
  input  logic [2*N-1:0]  dsp_out,
  output logic            rsp_valid,
  output logic            rsp_src,
  output logic [ID_W-1:0] rsp_id,
  output logic [2*N-1:0]  rsp_data,
  output logic            busy
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]     perf_issue0,
  output logic [31:0]     perf_issue1,
  output logic [31:0]     perf_stall
`endif
);
  typedef struct packed {
    logic            v;
    logic            src;
    logic [ID_W-1:0] id;
  } tag_t;
  tag_t tags [LAT+3];
  tag_t nxt [LAT+3];
  logic rr, lock_v, lock_own, e0, e1, win, go, drain, inflight, w_mac, h_mac;
  logic [1:0] cur_mode, cnt, w_mode, ii_m1, h_mode;
  logic [N-1:0] w_aa, w_bb, h_aa, h_bb;
  logic [2*N-1:0] w_cc, h_cc;
  logic [ID_W-1:0] w_id;
  always_comb begin
    e0 = r0_valid && !(lock_v && lock_own);
    e1 = r1_valid && !(lock_v && !lock_own);
    win = (e0 && e1) ? rr : e1;
    w_aa = win ? r1_aa : r0_aa;
    w_bb = win ? r1_bb : r0_bb;
    w_cc = win ? r1_cc : r0_cc;
    w_mac = win ? r1_mac : r0_mac;
    w_id = win ? r1_id : r0_id;
    w_mode = win ? {r1_mode[1], r1_mode[0] & ~r1_mode[1]} : {r0_mode[1], r0_mode[0] & ~r0_mode[1]};
    ii_m1 = w_mode[1] ? 2'd3 : {1'b0, w_mode[0]};
    // slot 0 retires this cycle, so only later slots hold back a mode change
    inflight = 1'b0;
    for (int i = 1; i < LAT + 3; i++) inflight |= tags[i].v;
    drain = (w_mode != cur_mode) && inflight;
    go = !rst && (e0 || e1) && cnt == 2'd0 && !drain;
    for (int i = 0; i < LAT + 2; i++) nxt[i] = tags[i+1];
    nxt[LAT+2] = '0;
    // entry position sets completion at LAT+II-1 cycles after issue
    for (int i = 0; i < LAT + 3; i++) if (go && i == LAT - 1 + int'(ii_m1)) nxt[i] = '{v: 1'b1, src: win, id: w_id};
  end
  assign r0_ready = go && !win;
  assign r1_ready = go && win;
  assign dsp_start = go;
  assign dsp_aa = go ? w_aa : h_aa;
  assign dsp_bb = go ? w_bb : h_bb;
  assign dsp_cc = go ? w_cc : h_cc;
  assign dsp_mode = go ? w_mode : h_mode;
  assign dsp_mac = go ? w_mac : h_mac;
  assign rsp_valid = !rst && tags[0].v;
  assign rsp_src = rsp_valid && tags[0].src;
  assign rsp_id = rsp_valid ? tags[0].id : '0;
  assign rsp_data = rsp_valid ? dsp_out : '0;
  assign busy = cnt != 2'd0 || inflight || tags[0].v;
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= 1'b0;
      lock_v <= 1'b0;
      lock_own <= 1'b0;
      cur_mode <= 2'd0;
      cnt <= 2'd0;
      h_aa <= '0;
      h_bb <= '0;
      h_cc <= '0;
      h_mode <= 2'd0;
      h_mac <= 1'b0;
      tags <= '{default: '0};
    end else begin
      tags <= nxt;
      cnt <= go ? ii_m1 : (cnt != 2'd0 ? cnt - 2'd1 : 2'd0);
      if (go) begin
        h_aa <= w_aa;
        h_bb <= w_bb;
        h_cc <= w_cc;
        h_mode <= w_mode;
        h_mac <= w_mac;
        cur_mode <= w_mode;
        // only the owner can win while locked, so this both sets and clears the lock
        lock_v <= w_mac;
        lock_own <= win;
        if (!lock_v) rr <= !win;
      end
    end
  end
`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue0 <= '0;
      perf_issue1 <= '0;
      perf_stall <= '0;
    end else begin
      perf_issue0 <= perf_issue0 + {31'd0, r0_ready};
      perf_issue1 <= perf_issue1 + {31'd0, r1_ready};
      perf_stall <= perf_stall + {31'd0, (r0_valid || r1_valid) && !go};
    end
  end
`endif
endmodule

// File: tb/tb_dsp_issue_sched.sv
// tb_dsp_issue_sched: scoreboard bench for dsp_issue_sched with a timestamp-based reference model
module tb_dsp_issue_sched;
  localparam int N = 16, LAT = 3, ID_W = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic r0_valid, r0_ready, r0_mac, r1_valid, r1_ready, r1_mac;
  logic [N-1:0] r0_aa, r0_bb, r1_aa, r1_bb, dsp_aa, dsp_bb;
  logic [2*N-1:0] r0_cc, r1_cc, dsp_cc, dsp_out, rsp_data;
  logic [1:0] r0_mode, r1_mode, dsp_mode;
  logic [ID_W-1:0] r0_id, r1_id, rsp_id;
  logic dsp_start, dsp_mac, rsp_valid, rsp_src, busy;
  dsp_issue_sched #(.N(N), .LAT(LAT), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_aa(r0_aa), .r0_bb(r0_bb), .r0_cc(r0_cc),
    .r0_mode(r0_mode), .r0_mac(r0_mac), .r0_id(r0_id),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_aa(r1_aa), .r1_bb(r1_bb), .r1_cc(r1_cc),
    .r1_mode(r1_mode), .r1_mac(r1_mac), .r1_id(r1_id),
    .dsp_start(dsp_start), .dsp_mode(dsp_mode), .dsp_mac(dsp_mac), .dsp_aa(dsp_aa),
    .dsp_bb(dsp_bb), .dsp_cc(dsp_cc), .dsp_out(dsp_out),
    .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [N-1:0] aa, bb;
    logic [2*N-1:0] cc;
    logic [1:0] mode;
    logic mac;
    logic [ID_W-1:0] id;
  } req_t;
  typedef struct {
    logic src;
    logic [ID_W-1:0] id;
    logic [2*N-1:0] data;
    int due;
  } exp_t;
  typedef struct {
    int due;
    logic [2*N-1:0] val;
  } dsp_t;
  req_t q0[$], q1[$];
  exp_t sb[$];
  dsp_t dq[$];
  int cyc = 0, errs = 0, checks = 0;
  bit gaps = 0, a0 = 0, a1 = 0;
  bit rr, lk, own, w, e0, e1, g, cool, drain, exp_busy;
  int li, lii, ld, cm, wm;
  logic [N-1:0] h_aa, h_bb;
  logic [2*N-1:0] h_cc;
  logic [1:0] h_mode;
  logic h_mac;
  function automatic int ii(input int m);
    return m == 0 ? 1 : m == 1 ? 2 : 4;
  endfunction
  function automatic int nm(input logic [1:0] m);
    return m == 2'd3 ? 2 : int'(m);
  endfunction
  function automatic logic [2*N-1:0] f(input logic [N-1:0] aa, bb, input logic [2*N-1:0] cc,
                                       input logic [1:0] mode, input logic mac);
    return (2*N)'(aa) * (2*N)'(bb) + cc + (2*N)'({mac, mode});
  endfunction
  function automatic req_t mk(input logic [N-1:0] aa, bb, input logic [2*N-1:0] cc,
                              input logic [1:0] mode, input logic mac, input logic [ID_W-1:0] id);
    req_t r;
    r.aa = aa; r.bb = bb; r.cc = cc; r.mode = mode; r.mac = mac; r.id = id;
    return r;
  endfunction
  function automatic req_t rnd(input logic [1:0] mode, input logic mac);
    return mk(N'($urandom), N'($urandom), (2*N)'($urandom), mode, mac, ID_W'($urandom));
  endfunction
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask
  task automatic model_reset();
    rr = 0; lk = 0; own = 0; li = -100; lii = 1; ld = -1; cm = 0;
    h_aa = '0; h_bb = '0; h_cc = '0; h_mode = '0; h_mac = 0;
    sb.delete();
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // request drivers: hold the queue head until the handshake completes
  initial forever begin
    @(posedge clk);
    #1;
    if (a0 && q0.size() > 0) void'(q0.pop_front());
    if (a1 && q1.size() > 0) void'(q1.pop_front());
    r0_valid = q0.size() > 0 && !(gaps && $urandom_range(3) == 0);
    if (q0.size() > 0) {r0_aa, r0_bb, r0_cc, r0_mode, r0_mac, r0_id} = {q0[0].aa, q0[0].bb, q0[0].cc, q0[0].mode, q0[0].mac, q0[0].id};
    r1_valid = q1.size() > 0 && !(gaps && $urandom_range(3) == 0);
    if (q1.size() > 0) {r1_aa, r1_bb, r1_cc, r1_mode, r1_mac, r1_id} = {q1[0].aa, q1[0].bb, q1[0].cc, q1[0].mode, q1[0].mac, q1[0].id};
  end
  // behavioural DSP: result appears LAT+II-1 cycles after its start
  always @(negedge clk) begin
    if (rst) dq.delete();
    else if (dsp_start) dq.push_back('{due: cyc + LAT + ii(nm(dsp_mode)) - 1, val: f(dsp_aa, dsp_bb, dsp_cc, dsp_mode, dsp_mac)});
  end
  always @(posedge clk) begin
    dsp_t t;
    #1;
    while (dq.size() > 0 && dq[0].due < cyc) void'(dq.pop_front());
    if (dq.size() > 0 && dq[0].due == cyc) begin
      t = dq.pop_front();
      dsp_out = t.val;
    end else dsp_out = (2*N)'($urandom);
  end
  // reference model: grant decisions from timestamps, rr pointer and lock owner
  always @(negedge clk) begin
    a0 = r0_valid && r0_ready;
    a1 = r1_valid && r1_ready;
    if (rst) begin
      chk("ready_in_reset", {r0_ready, r1_ready, dsp_start}, 3'b000);
      model_reset();
    end else begin
      e0 = r0_valid && !(lk && own != 0);
      e1 = r1_valid && !(lk && own != 1);
      w = (e0 && e1) ? rr : e1;
      wm = nm(w ? r1_mode : r0_mode);
      cool = cyc < li + lii;
      drain = wm != cm && ld > cyc;
      g = (e0 || e1) && !cool && !drain;
      exp_busy = (cyc > li && cyc < li + lii) || ld >= cyc;
      chk("busy", busy, exp_busy);
      chk("grant", {r0_ready, r1_ready, dsp_start}, g ? (w ? 3'b011 : 3'b101) : 3'b000);
      if (g) begin
        h_aa = w ? r1_aa : r0_aa;
        h_bb = w ? r1_bb : r0_bb;
        h_cc = w ? r1_cc : r0_cc;
        h_mode = 2'(wm);
        h_mac = w ? r1_mac : r0_mac;
        sb.push_back('{src: w, id: w ? r1_id : r0_id, data: f(h_aa, h_bb, h_cc, h_mode, h_mac), due: cyc + LAT + ii(wm) - 1});
        li = cyc;
        lii = ii(wm);
        cm = wm;
        ld = cyc + LAT + ii(wm) - 1;
        if (!lk) rr = !w;
        lk = h_mac;
        own = w;
      end
      chk("dsp_fields", {dsp_aa, dsp_bb, dsp_cc, dsp_mode, dsp_mac}, {h_aa, h_bb, h_cc, h_mode, h_mac});
    end
  end
  // monitor: pops the scoreboard whenever a response is presented or due
  always @(negedge clk) begin
    exp_t e;
    if (rst) chk("rsp_in_reset", rsp_valid, 1'b0);
    else if (rsp_valid) begin
      if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 1'b0);
      else begin
        e = sb.pop_front();
        chk("rsp", {rsp_src, rsp_id, rsp_data, cyc}, {e.src, e.id, e.data, e.due});
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      chk("rsp_missing", rsp_valid, 1'b1);
      void'(sb.pop_front());
    end
  end
  task automatic wait_idle();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("idle_timeout", q0.size() + q1.size() + sb.size(), 0);
    repeat (2) @(posedge clk);
    #2;
  endtask
  initial begin
    {r0_valid, r1_valid, r0_aa, r0_bb, r0_cc, r0_mode, r0_mac, r0_id} = '0;
    {r1_aa, r1_bb, r1_cc, r1_mode, r1_mac, r1_id, dsp_out} = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst = 0;
    for (int i = 0; i < 8; i++) q0.push_back(mk(3, 5, 0, 0, 0, ID_W'(i)));
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(rnd(2, 0));
      q1.push_back(rnd(2, 0));
    end
    wait_idle();
    q0.push_back(rnd(0, 0));
    q0.push_back(rnd(0, 0));
    q0.push_back(rnd(1, 0));
    wait_idle();
    for (int i = 0; i < 3; i++) q0.push_back(rnd(0, 1));
    q0.push_back(rnd(0, 0));
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) q1.push_back(rnd(0, 0));
    wait_idle();
    q0.push_back(rnd(2, 0));
    for (int n = 0; n < 50 && q0.size() > 0; n++) begin
      @(posedge clk);
      #2;
    end
    rst = 1;
    q0.push_back(rnd(0, 0));
    @(posedge clk);
    #2 rst = 0;
    wait_idle();
    for (int i = 0; i < 3; i++) q0.push_back(rnd(3, 0));
    for (int i = 0; i < 2; i++) q1.push_back(rnd(3, 0));
    wait_idle();
    gaps = 1;
    for (int i = 0; i < 40; i++) begin
      q0.push_back(rnd(2'($urandom), i < 39 && $urandom_range(3) == 0));
      q1.push_back(rnd(2'($urandom), i < 39 && $urandom_range(3) == 0));
    end
    wait_idle();
    gaps = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
